sound_event_scheduler: RTL and testbench

- Sits between the chess game logic and the sound-effect player.
- Collects one-cycle sound event requests (codes 1..7: select, cancel, move, capture, illegal, promotion, game over) into a sticky pending set.
- Picks the highest-priority pending event and issues it to the player as a play_sound pulse plus a stable sound_code.
- Waits for the player's start/busy flag to rise and fall, then enforces a minimum inter-sound gap, so no request restarts a sound mid-playback.

---
 rtl/sound_event_scheduler.sv | 121 ++++++++++++
 tb/tb_sound_event_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sound_event_scheduler.sv
// Sound event scheduler: sticky pending set, highest-code-first issue, ack/done handshake, inter-sound gap.
// Optional mute support is compiled in with `define SOUND_MUTE_EN.
module sound_event_scheduler #(
  parameter int ACK_TIMEOUT = 16,
  parameter int GAP_CYCLES  = 1000000,
  parameter int CNT_W       = 24
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [6:0] req,
  input  logic       player_busy,
  input  logic       mute,
  output logic       play_sound,
  output logic [2:0] sound_code,
  output logic [6:0] pending,
  output logic       sched_busy
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    GAP
  } state_e;

  // Terminal counts; a zero parameter collapses to a compare that is always true.
  localparam logic [CNT_W-1:0] ACK_LAST = (ACK_TIMEOUT > 0) ? CNT_W'(ACK_TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       pend_q, pend_d;
  logic [2:0]       code_q, code_d;
  logic [2:0]       sel;
  logic [6:0]       clr;
  logic             mute_act;

`ifdef SOUND_MUTE_EN
  assign mute_act = mute;
`else
  logic unused_mute;
  assign unused_mute = mute;
  assign mute_act    = 1'b0;
`endif

  // Highest set bit wins; later loop iterations override earlier ones.
  always_comb begin
    sel = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (pend_q[i]) sel = 3'(i + 1);
    end
  end

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    clr     = '0;
    case (state_q)
      IDLE: begin
        if (pend_q != '0 && !mute_act) begin
          code_d  = sel;
          clr     = (sel == 3'd7) ? 7'h7F : (7'b1 << (sel - 3'd1));
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (player_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q >= ACK_LAST) begin
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!player_busy) begin
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_q >= GAP_LAST) state_d = IDLE;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
    // New requests win over the clear of the code being selected.
    pend_d = mute_act ? '0 : ((pend_q & ~clr) | req);
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch; state uses <= only.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    play_sound = (state_q == ISSUE);
    sched_busy = (state_q != IDLE);
    sound_code = code_q;
    pending    = pend_q;
  end

endmodule

// File: tb/tb_sound_event_scheduler.sv
// Scoreboard bench for sound_event_scheduler: timeline reference model, scripted player, random bursts.
module tb_sound_event_scheduler;
  localparam int ACK = 16;
  localparam int GAP = 20;
`ifdef SOUND_MUTE_EN
  localparam bit MUTE_EN = 1'b1;
`else
  localparam bit MUTE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [6:0] req = '0;
  logic       player_busy = 1'b0;
  logic       mute = 1'b0;
  logic       play_sound;
  logic [2:0] sound_code;
  logic [6:0] pending;
  logic       sched_busy;

  sound_event_scheduler #(.ACK_TIMEOUT(ACK), .GAP_CYCLES(GAP), .CNT_W(24)) dut (
    .clk(clk), .rstn(rstn), .req(req), .player_busy(player_busy), .mute(mute),
    .play_sound(play_sound), .sound_code(sound_code), .pending(pending), .sched_busy(sched_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, edge_n);
  endtask

  typedef struct {
    int code;
    int cyc;
  } issue_t;
  issue_t exp_q[$];

  // Reference model: pending set plus the edge at which the scheduler is idle again.
  logic [6:0] m_pend = '0;
  int         m_idle = 0;
  int         m_code = 0;
  int         last_rst_edge = -1;
  bit         chk_en = 1'b0;
  int         p_delay = 1;
  int         p_len = 100;
  bit         p_dead = 1'b0;

  function automatic int top_code(input logic [6:0] m);
    for (int i = 6; i >= 0; i--) if (m[i]) return i + 1;
    return 0;
  endfunction

  always @(posedge clk) begin : model
    logic [6:0] nxt;
    int c;
    edge_n++;
    if (!rstn) begin
      m_pend = '0;
      m_idle = edge_n;
      m_code = 0;
      last_rst_edge = edge_n;
      exp_q.delete();
      chk_en = 1'b1;
    end else begin
      nxt = m_pend;
      if (MUTE_EN && mute) begin
        nxt = '0;
      end else if (edge_n > m_idle && m_pend != '0) begin
        c = top_code(m_pend);
        nxt = (c == 7) ? 7'h00 : (m_pend & ~(7'b1 << (c - 1)));
        exp_q.push_back('{c, edge_n});
        m_code = c;
        // Issue cycle, then ack wait (delay or full timeout), playback, and the gap.
        m_idle = p_dead ? edge_n + 1 + ACK + GAP : edge_n + 2 + p_delay + p_len + GAP;
      end
      if (!(MUTE_EN && mute)) nxt = nxt | req;
      m_pend = nxt;
    end
  end

  // Player: busy for p_len cycles starting p_delay cycles after the issue cycle.
  int p_start = -1;
  int p_end = -2;
  always @(negedge clk) begin
    if (last_rst_edge == edge_n) begin
      p_start = -1;
      p_end = -2;
    end
    if (play_sound && !p_dead) begin
      p_start = edge_n + 1 + p_delay;
      p_end = edge_n + p_delay + p_len;
    end
    player_busy = (edge_n >= p_start && edge_n <= p_end);
  end

  // Monitor: pops the scoreboard on each pulse and compares registered outputs every cycle.
  always @(negedge clk) begin : monitor
    issue_t e;
    if (chk_en) begin
      if (play_sound) begin
        if (exp_q.size() == 0) begin
          check("unexpected_play", int'(play_sound), 0);
        end else begin
          e = exp_q.pop_front();
          check("issue_code", int'(sound_code), e.code);
          check("issue_cycle", edge_n, e.cyc);
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc < edge_n) begin
        e = exp_q.pop_front();
        check("missed_play", int'(play_sound), 1);
      end
      check("sound_code", int'(sound_code), m_code);
      check("pending", int'(pending), int'(m_pend));
      check("sched_busy", int'(sched_busy), int'(edge_n < m_idle));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [6:0] m);
    @(negedge clk);
    req = m;
    @(negedge clk);
    req = '0;
  endtask

  task automatic wait_quiet();
    int t = 0;
    while ((m_pend != '0 || edge_n < m_idle || exp_q.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) check("quiet_timeout", t, 0);
    cycles(2);
    check("quiet_busy", int'(sched_busy), 0);
    check("quiet_pending", int'(pending), 0);
  endtask

  initial begin
    cycles(3);
    rstn = 1'b1;
    cycles(2);
    check("reset_play", int'(play_sound), 0);
    check("reset_code", int'(sound_code), 0);

    // Single sound, then two simultaneous codes.
    pulse(7'b0000100);
    wait_quiet();
    pulse(7'b0001001);
    wait_quiet();

    // Requests arriving during playback, including a duplicate that merges.
    pulse(7'b0000100);
    cycles(10);
    pulse(7'b0000010);
    cycles(5);
    pulse(7'b0010000);
    cycles(5);
    pulse(7'b0000010);
    wait_quiet();

    // Game over clears {1,3}; a code-2 request on the selection edge survives.
    @(negedge clk);
    req = 7'b1000101;
    @(negedge clk);
    req = 7'b0000010;
    @(negedge clk);
    req = '0;
    wait_quiet();

    // Lost sounds: player never answers.
    p_dead = 1'b1;
    pulse(7'b0100000);
    cycles(5);
    pulse(7'b0000010);
    wait_quiet();
    p_dead = 1'b0;

    // Reset during playback with code 2 pending.
    pulse(7'b0001000);
    cycles(10);
    pulse(7'b0000010);
    cycles(3);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("post_reset_busy", int'(sched_busy), 0);
    check("post_reset_pending", int'(pending), 0);
    cycles(30);
    pulse(7'b0000001);
    wait_quiet();

    if (MUTE_EN) begin
      @(negedge clk);
      mute = 1'b1;
      pulse(7'b0100000);
      cycles(10);
      check("mute_pending", int'(pending), 0);
      @(negedge clk);
      mute = 1'b0;
      pulse(7'b0000100);
      wait_quiet();
    end

    // Randomized bursts with a varying player.
    for (int r = 0; r < 15; r++) begin
      p_delay = $urandom_range(0, 6);
      p_len = $urandom_range(1, 30);
      p_dead = ($urandom_range(0, 9) == 0);
      repeat (40) begin
        @(negedge clk);
        req = ($urandom_range(0, 4) == 0) ? 7'($urandom) : 7'h00;
      end
      @(negedge clk);
      req = '0;
      wait_quiet();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
